// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } tx_feed_state_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // Default bit period in clocks, shared with the serial transmitter.
  localparam int CLK_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for the transmit feeder: synchronous write port, asynchronous read port.
module uart_tx_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [1<<DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Circular byte FIFO that paces bytes into the UART transmitter using tx_busy as handshake.
// Optional TX_FEEDER_CRLF_EN: expands each queued LF into CR,LF on the wire.
//
// state     | meaning
// IDLE      | waiting for a queued byte and an idle transmitter
// WAIT_ACK  | byte issued, waiting for tx_busy to rise (down-counted timeout)
// WAIT_DONE | transmitter busy with the issued byte
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  ack_err,
  output logic [7:0]            tx_data,
  output logic                  tx_new_data,
  input  logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);

  tx_feed_state_e        state;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      ack_cnt;
  logic                  head_valid;
  logic [7:0]            head_data;
  logic                  wr_ok, issue, pop, insert_cr;
  logic [7:0]            issue_data;
  logic [DEPTH_LOG2:0]   level_next;
`ifdef TX_FEEDER_CRLF_EN
  logic                  crlf_pend;
`endif

  uart_tx_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  always_comb begin
    wr_ok = wr_en && !full;
    // head_valid lags empty by a cycle so a freshly written head is issued from a settled slot
    issue = (state == IDLE) && head_valid && !empty && !tx_busy;
`ifdef TX_FEEDER_CRLF_EN
    insert_cr = (head_data == ASCII_LF) && !crlf_pend;
`else
    insert_cr = 1'b0;
`endif
    pop        = issue && !insert_cr;
    issue_data = insert_cr ? ASCII_CR : head_data;
    level_next = level;
    if (wr_ok && !pop)      level_next = level + 1'b1;
    else if (!wr_ok && pop) level_next = level - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      overflow    <= 1'b0;
      ack_err     <= 1'b0;
      tx_new_data <= 1'b0;
      tx_data     <= 8'h00;
      ack_cnt     <= '0;
      head_valid  <= 1'b0;
`ifdef TX_FEEDER_CRLF_EN
      crlf_pend   <= 1'b0;
`endif
    end else begin
      overflow    <= wr_en && full;
      ack_err     <= 1'b0;
      tx_new_data <= 1'b0;
      head_valid  <= !empty;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == LEVEL_FULL);
      case (state)
        IDLE: begin
          if (issue) begin
            tx_data     <= issue_data;
            tx_new_data <= 1'b1;
            ack_cnt     <= ACK_LOAD;
            state       <= WAIT_ACK;
`ifdef TX_FEEDER_CRLF_EN
            crlf_pend   <= insert_cr;
`endif
          end
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == '0) begin
            ack_err <= 1'b1;
            state   <= IDLE;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter busy model.
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty, overflow, ack_err, tx_new_data, tx_busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  logic       hold_busy;
  logic       model_en;
  int         busy_len;
  int         busy_cnt = 0;
  int         strobes = 0;
  int         ovf_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] rx_q[$];
  logic [4:0] lvl_q[$];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[18];

  uart_tx_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .ack_err     (ack_err),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .tx_busy     (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after the strobe and lasts busy_len cycles.
  always @(posedge clk) begin
    if (tx_new_data) begin
      rx_q.push_back(tx_data);
      lvl_q.push_back(level);
      strobes++;
    end
    if (overflow) ovf_cnt++;
    if (ack_err) err_cnt++;
    if (tx_new_data && model_en) busy_cnt <= busy_len;
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = hold_busy || (busy_cnt != 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input int base, input int n, input int budget);
    int c = 0;
    while ((rx_q.size() - base) < n && c < budget) begin
      tick();
      c++;
    end
    check("rx_count", rx_q.size() - base, n);
  endtask

  initial begin
    int base, sbase, obase, ebase;
    logic [7:0] exp_b[$];
    logic [4:0] exp_l[$];

    for (int i = 0; i < 17; i++) begin
      vecs[i].wr        = 1'b1;
      vecs[i].data      = 8'h80 + 8'(i);
      vecs[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
      vecs[i].exp_full  = (i >= 15);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_ovf   = (i == 16);
    end
    vecs[17].wr        = 1'b0;
    vecs[17].data      = 8'h00;
    vecs[17].exp_level = 5'd16;
    vecs[17].exp_full  = 1'b1;
    vecs[17].exp_empty = 1'b0;
    vecs[17].exp_ovf   = 1'b0;

    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    hold_busy = 1'b0;
    model_en  = 1'b1;
    busy_len  = 3;
    repeat (3) tick();
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_new_data", tx_new_data, 0);
    check("rst_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // single byte latency
    sbase = strobes;
    base  = rx_q.size();
    wr(8'hA5);
    check("t1_level_k", level, 1);
    check("t1_strobe_k", tx_new_data, 0);
    tick();
    check("t1_strobe_k1", tx_new_data, 0);
    tick();
    check("t1_strobe_k2", tx_new_data, 1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_empty", empty, 1);
    repeat (10) tick();
    check("t1_strobes", strobes - sbase, 1);
    check("t1_data_hold", tx_data, 8'hA5);

    // fill and overflow with the transmitter blocked
    hold_busy = 1'b1;
    obase = ovf_cnt;
    base  = rx_q.size();
    tick();
    for (int i = 0; i < 18; i++) begin
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].data;
      tick();
      check("fill_level", level, vecs[i].exp_level);
      check("fill_full", full, vecs[i].exp_full);
      check("fill_empty", empty, vecs[i].exp_empty);
      check("fill_ovf", overflow, vecs[i].exp_ovf);
    end
    wr_en = 1'b0;
    check("fill_ovf_count", ovf_cnt - obase, 1);
    check("fill_no_issue", rx_q.size() - base, 0);
    hold_busy = 1'b0;
    wait_rx(base, 16, 400);
    for (int i = 0; i < 16; i++)
      if (rx_q.size() > base + i) check("fill_order", rx_q[base+i], 8'h80 + 8'(i));
    repeat (10) tick();
    check("fill_drained_level", level, 0);
    check("fill_drained_empty", empty, 1);

    // simultaneous write and pop, streaming across pointer wrap
    hold_busy = 1'b1;
    obase = ovf_cnt;
    base  = rx_q.size();
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    tick();
    check("sim_level_pre", level, 5);
    hold_busy = 1'b0;
    wr_data   = 8'h15;
    wr_en     = 1'b1;
    tick();
    wr_en = 1'b0;
    check("sim_level", level, 5);
    check("sim_strobe", tx_new_data, 1);
    check("sim_data", tx_data, 8'h10);
    for (int b = 8'h16; b <= 8'h2F; b++) begin
      int c = 0;
      while (full && c < 100) begin
        tick();
        c++;
      end
      wr(8'(b));
    end
    wait_rx(base, 32, 800);
    for (int i = 0; i < 32; i++)
      if (rx_q.size() > base + i) check("sim_order", rx_q[base+i], 8'h10 + 8'(i));
    check("sim_no_ovf", ovf_cnt - obase, 0);
    repeat (10) tick();

    // ack timeout: transmitter never raises busy
    model_en = 1'b0;
    ebase    = err_cnt;
    wr_data  = 8'h55;
    wr_en    = 1'b1;
    tick();
    wr_data  = 8'h66;
    tick();
    wr_en = 1'b0;
    tick();
    check("to_strobe1", tx_new_data, 1);
    check("to_data1", tx_data, 8'h55);
    repeat (3) tick();
    check("to_err_early", ack_err, 0);
    tick();
    check("to_err", ack_err, 1);
    tick();
    check("to_err_pulse", ack_err, 0);
    check("to_strobe2", tx_new_data, 1);
    check("to_data2", tx_data, 8'h66);
    repeat (8) tick();
    check("to_err_count", err_cnt - ebase, 2);
    model_en = 1'b1;
    repeat (4) tick();

    // LF handling
    base = rx_q.size();
`ifdef TX_FEEDER_CRLF_EN
    exp_b.push_back(8'h41); exp_l.push_back(5'd1);
    exp_b.push_back(8'h0D); exp_l.push_back(5'd1);
    exp_b.push_back(8'h0A); exp_l.push_back(5'd0);
`else
    exp_b.push_back(8'h41); exp_l.push_back(5'd1);
    exp_b.push_back(8'h0A); exp_l.push_back(5'd0);
`endif
    wr(8'h41);
    wr(8'h0A);
    wait_rx(base, exp_b.size(), 200);
    repeat (10) tick();
    check("lf_total", rx_q.size() - base, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (rx_q.size() > base + i) begin
        check("lf_byte", rx_q[base+i], exp_b[i]);
        check("lf_level", lvl_q[base+i], exp_l[i]);
      end

    // reset mid-transfer
    busy_len = 6;
    base  = rx_q.size();
    sbase = strobes;
    wr(8'h31);
    wr(8'h32);
    wr(8'h33);
    tick();
    tick();
    check("rst_mid_level_pre", level, 2);
    check("rst_mid_busy_pre", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_level", level, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_strobe", tx_new_data, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("rst_mid_strobes", strobes - sbase, 1);
    if (rx_q.size() > base) check("rst_mid_byte", rx_q[base], 8'h31);
    check("rst_mid_busy_done", tx_busy, 0);
    check("rst_mid_empty_post", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
